// File: rtl/instr_fetch_decode.sv
// PDP-8 instruction fetch/decode stage feeding instr_exec; owns a read-only port into memory.
// Optional feature macro IFD_INSTR_COUNT_EN adds a 32-bit instr_count output.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef struct packed {
    logic ind;
    logic and_op;
    logic tad;
    logic isz;
    logic dca;
    logic jms;
    logic jmp;
  } pdp_mem_opcode_s;

  // grp1/grp2 tell instr_exec which micro-op group the shared flags belong to.
  typedef struct packed {
    logic grp1;
    logic grp2;
    logic cla;
    logic cll;
    logic cma;
    logic cml;
    logic rar;
    logic ral;
    logic bsw;
    logic iac;
    logic sma;
    logic sza;
    logic snl;
    logic rss;
    logic osr;
    logic hlt;
  } pdp_op7_opcode_s;

endpackage

module instr_fetch_decode
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  input  logic                  stall,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifd_valid,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  halted
`ifdef IFD_INSTR_COUNT_EN
  ,
  output logic [31:0]           instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WAIT    = 3'd1,
    S_PRESENT = 3'd2,
    S_EXEC    = 3'd3,
    S_HALTED  = 3'd4
  } state_e;

  state_e                state_r;
  state_e                state_s;
  logic [DATA_WIDTH-1:0] ir_r;
  logic [ADDR_WIDTH-8:0] page_r;
  pdp_mem_opcode_s       dec_mem_s;
  pdp_op7_opcode_s       dec_op7_s;
  logic [ADDR_WIDTH-1:0] dec_base_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; FETCH lingers until the registered request is actually on the port.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (ifu_rd_req) state_s = S_WAIT;
        else            state_s = S_FETCH;
      end
      S_WAIT: state_s = S_PRESENT;
      S_PRESENT: begin
        if (stall) state_s = S_EXEC;
        else       state_s = S_PRESENT;
      end
      S_EXEC: begin
        if (stall)                                          state_s = S_EXEC;
        else if (pdp_op7_opcode.grp2 && pdp_op7_opcode.hlt) state_s = S_HALTED;
        else                                                state_s = S_FETCH;
      end
      S_HALTED: state_s = S_HALTED;
      default:  state_s = S_FETCH;
    endcase
  end

  // Instruction register and the fetch page, both taken while the read data is on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_r   <= '0;
      page_r <= '0;
    end else if (state_r == S_WAIT) begin
      ir_r   <= ifu_rd_data;
      page_r <= PC_value[ADDR_WIDTH-1:7];
    end
  end

  // Decode of the held instruction word.
  always_comb begin
    dec_mem_s = '0;
    dec_op7_s = '0;
    if (ir_r[7]) dec_base_s = {page_r, ir_r[6:0]};
    else         dec_base_s = {{(ADDR_WIDTH-7){1'b0}}, ir_r[6:0]};
    case (ir_r[11:9])
      3'd0: dec_mem_s.and_op = 1'b1;
      3'd1: dec_mem_s.tad    = 1'b1;
      3'd2: dec_mem_s.isz    = 1'b1;
      3'd3: dec_mem_s.dca    = 1'b1;
      3'd4: dec_mem_s.jms    = 1'b1;
      3'd5: dec_mem_s.jmp    = 1'b1;
      3'd6: dec_mem_s        = '0;
      3'd7: begin
        if (!ir_r[8]) begin
          dec_op7_s.grp1 = 1'b1;
          dec_op7_s.cla  = ir_r[7];
          dec_op7_s.cll  = ir_r[6];
          dec_op7_s.cma  = ir_r[5];
          dec_op7_s.cml  = ir_r[4];
          dec_op7_s.rar  = ir_r[3];
          dec_op7_s.ral  = ir_r[2];
          dec_op7_s.bsw  = ir_r[1];
          dec_op7_s.iac  = ir_r[0];
        end else if (!ir_r[0]) begin
          dec_op7_s.grp2 = 1'b1;
          dec_op7_s.cla  = ir_r[7];
          dec_op7_s.sma  = ir_r[6];
          dec_op7_s.sza  = ir_r[5];
          dec_op7_s.snl  = ir_r[4];
          dec_op7_s.rss  = ir_r[3];
          dec_op7_s.osr  = ir_r[2];
          dec_op7_s.hlt  = ir_r[1];
        end else begin
          // Group 3 (EAE) words decode to a NOP.
          dec_op7_s = '0;
        end
      end
      default: dec_mem_s = '0;
    endcase
    if (ir_r[11:9] < 3'd6) dec_mem_s.ind = ir_r[8];
    else                   dec_mem_s.ind = 1'b0;
  end

  // Registered port outputs: request, address, decoded fields and halt flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifu_rd_req     <= 1'b0;
      ifu_rd_addr    <= '0;
      ifd_valid      <= 1'b0;
      base_addr      <= '0;
      pdp_mem_opcode <= '0;
      pdp_op7_opcode <= '0;
      halted         <= 1'b0;
    end else begin
      ifu_rd_req <= (state_s == S_FETCH);
      halted     <= (state_s == S_HALTED);
      if (state_s == S_FETCH) begin
        ifu_rd_addr <= PC_value;
      end
      case (state_r)
        S_PRESENT: begin
          ifd_valid      <= 1'b1;
          base_addr      <= dec_base_s;
          pdp_mem_opcode <= dec_mem_s;
          pdp_op7_opcode <= dec_op7_s;
        end
        S_EXEC: begin
          if (!stall) begin
            ifd_valid      <= 1'b0;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
          end
        end
        default: begin
          ifd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFD_INSTR_COUNT_EN
  // Counts instructions handed to the execution unit; HALTED has no PRESENT->EXEC edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= 32'd0;
    end else if ((state_r == S_PRESENT) && (state_s == S_EXEC)) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized self-checking bench for instr_fetch_decode with a spec-level decode model.
module tb_instr_fetch_decode;
  import pdp8_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            stall = 1'b0;
  logic [11:0]     PC_value = 12'd0;
  logic            ifu_rd_req;
  logic [11:0]     ifu_rd_addr;
  logic [11:0]     ifu_rd_data = 12'd0;
  logic            ifd_valid;
  logic [11:0]     base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            halted;
`ifdef IFD_INSTR_COUNT_EN
  logic [31:0]     instr_count;
`endif

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  logic [11:0] mem [0:4095];

  instr_fetch_decode dut (
    .clk(clk),
    .reset_n(reset_n),
    .PC_value(PC_value),
    .stall(stall),
    .ifu_rd_req(ifu_rd_req),
    .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data),
    .ifd_valid(ifd_valid),
    .base_addr(base_addr),
    .pdp_mem_opcode(pdp_mem_opcode),
    .pdp_op7_opcode(pdp_op7_opcode),
    .halted(halted)
`ifdef IFD_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: data one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    if (ifu_rd_req) begin
      ifu_rd_data <= mem[ifu_rd_addr];
      req_count   <= req_count + 1;
    end else begin
      ifu_rd_data <= 12'($urandom);
    end
  end

  function automatic void model(input logic [11:0] w, input logic [11:0] pc,
                                output pdp_mem_opcode_s m, output pdp_op7_opcode_s o,
                                output logic [11:0] b);
    int op, off, page;
    op   = int'(w) / 512;
    off  = int'(w) % 128;
    page = (int'(pc) / 128) * 128;
    m = '0;
    o = '0;
    b = w[7] ? 12'(page + off) : 12'(off);
    if (op < 6) begin
      m.ind = w[8];
      case (op)
        0: m.and_op = 1'b1;
        1: m.tad = 1'b1;
        2: m.isz = 1'b1;
        3: m.dca = 1'b1;
        4: m.jms = 1'b1;
        default: m.jmp = 1'b1;
      endcase
    end else if (op == 7 && w[8] == 1'b0) begin
      o.grp1 = 1'b1; o.cla = w[7]; o.cll = w[6]; o.cma = w[5]; o.cml = w[4];
      o.rar = w[3]; o.ral = w[2]; o.bsw = w[1]; o.iac = w[0];
    end else if (op == 7 && w[0] == 1'b0) begin
      o.grp2 = 1'b1; o.cla = w[7]; o.sma = w[6]; o.sza = w[5]; o.snl = w[4];
      o.rss = w[3]; o.osr = w[2]; o.hlt = w[1];
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, then counts cycles until ifd_valid; lat = -1 on timeout.
  task automatic fetch_to_valid(input logic [11:0] pc, input logic [11:0] w, input bit early,
                                output int lat, output logic [11:0] addr_seen);
    int n;
    n = 0;
    mem[pc] = w;
    PC_value = pc;
    lat = -1;
    addr_seen = 12'd0;
    while (!ifu_rd_req && n < 10) begin
      step();
      n++;
    end
    if (!ifu_rd_req) return;
    addr_seen = ifu_rd_addr;
    if (early) stall = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (ifd_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #2;
    checks++;
    if ({ifu_rd_req, ifu_rd_addr, ifd_valid, base_addr, halted} !== 27'd0) begin
      errors++;
      $display("FAIL reset_ports: got %h want 0", {ifu_rd_req, ifu_rd_addr, ifd_valid, base_addr, halted});
    end
    checks++;
    if ({pdp_mem_opcode, pdp_op7_opcode} !== 23'd0) begin
      errors++;
      $display("FAIL reset_opcodes: got %h want 0", {pdp_mem_opcode, pdp_op7_opcode});
    end
  endtask

  task automatic test_tad();
    int lat; logic [11:0] a, eb; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    PC_value = 12'o0200;
    step(); step();
    reset_n = 1'b1;
    fetch_to_valid(12'o0200, 12'o1377, 1'b0, lat, a);
    model(12'o1377, 12'o0200, em, eo, eb);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL tad_latency: got %0d want 3", lat); end
    checks++;
    if (a !== 12'o0200) begin errors++; $display("FAIL tad_addr: got %o want 0200", a); end
    checks++;
    if ({pdp_mem_opcode, pdp_op7_opcode, base_addr} !== {em, eo, eb}) begin
      errors++;
      $display("FAIL tad_decode: got %h want %h", {pdp_mem_opcode, pdp_op7_opcode, base_addr}, {em, eo, eb});
    end
    checks++;
    if (!(pdp_mem_opcode.tad === 1'b1 && pdp_mem_opcode.ind === 1'b0 && base_addr === 12'o0377)) begin
      errors++;
      $display("FAIL tad_fields: got tad=%b i=%b base=%o want 1 0 0377", pdp_mem_opcode.tad, pdp_mem_opcode.ind, base_addr);
    end
    stall = 1'b1; step();
    stall = 1'b0; PC_value = 12'o0600; step();
  endtask

  task automatic test_jmp();
    int lat; logic [11:0] a, eb; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    fetch_to_valid(12'o0600, 12'o5420, 1'b0, lat, a);
    model(12'o5420, 12'o0600, em, eo, eb);
    checks++;
    if (lat !== 3 || a !== 12'o0600) begin errors++; $display("FAIL jmp_fetch: got lat=%0d addr=%o want 3 0600", lat, a); end
    checks++;
    if ({pdp_mem_opcode, pdp_op7_opcode, base_addr} !== {em, eo, eb} || base_addr !== 12'o0020 || pdp_mem_opcode.jmp !== 1'b1) begin
      errors++;
      $display("FAIL jmp_decode: got %h want %h", {pdp_mem_opcode, pdp_op7_opcode, base_addr}, {em, eo, eb});
    end
    stall = 1'b1; step();
    stall = 1'b0; PC_value = 12'o1000; step();
  endtask

  task automatic test_group1();
    int lat; logic [11:0] a, eb; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    fetch_to_valid(12'o1000, 12'o7300, 1'b0, lat, a);
    model(12'o7300, 12'o1000, em, eo, eb);
    checks++;
    if ({pdp_mem_opcode, pdp_op7_opcode} !== {em, eo} || pdp_mem_opcode !== 7'd0 ||
        pdp_op7_opcode.cla !== 1'b1 || pdp_op7_opcode.cll !== 1'b1) begin
      errors++;
      $display("FAIL group1_decode: got %h want %h", {pdp_mem_opcode, pdp_op7_opcode}, {em, eo});
    end
    stall = 1'b1; step();
    stall = 1'b0; PC_value = 12'o2000; step();
  endtask

  task automatic test_stall_hold();
    int lat; logic [11:0] a, eb; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    int bad;
    bad = 0;
    fetch_to_valid(12'o2000, 12'o3456, 1'b0, lat, a);
    model(12'o3456, 12'o2000, em, eo, eb);
    stall = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ifd_valid !== 1'b1 || ifu_rd_req !== 1'b0 ||
          {pdp_mem_opcode, pdp_op7_opcode, base_addr} !== {em, eo, eb}) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
    stall = 1'b0; PC_value = 12'o2400; step();
    checks++;
    if ({ifu_rd_req, ifu_rd_addr, ifd_valid} !== {1'b1, 12'o2400, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%o valid=%b want 1 2400 0", ifu_rd_req, ifu_rd_addr, ifd_valid);
    end
  endtask

  task automatic test_random();
    int lat, pre, hold; logic [11:0] a, eb, pc, npc, w; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    bit early;
    pc = 12'o2400;
    for (int i = 0; i < 40; i++) begin
      w = 12'($urandom);
      if (w[11:9] == 3'd7 && w[8] && !w[0]) w[1] = 1'b0;
      early = ($urandom_range(0, 3) == 0);
      fetch_to_valid(pc, w, early, lat, a);
      model(w, pc, em, eo, eb);
      checks++;
      if (lat !== 3 || a !== pc) begin errors++; $display("FAIL rnd_fetch: got lat=%0d addr=%o want 3 %o", lat, a, pc); end
      checks++;
      if ({ifd_valid, pdp_mem_opcode, pdp_op7_opcode, base_addr} !== {1'b1, em, eo, eb}) begin
        errors++;
        $display("FAIL rnd_decode: word %o got %h want %h", w, {ifd_valid, pdp_mem_opcode, pdp_op7_opcode, base_addr}, {1'b1, em, eo, eb});
      end
      pre = early ? 0 : $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      for (int c = 0; c < pre + hold; c++) begin
        if (c == pre) stall = 1'b1;
        step();
        checks++;
        if ({ifu_rd_req, ifd_valid, pdp_mem_opcode, pdp_op7_opcode, base_addr} !== {1'b0, 1'b1, em, eo, eb}) begin
          errors++;
          $display("FAIL rnd_hold: word %o cycle %0d got %h", w, c, {ifu_rd_req, ifd_valid, pdp_mem_opcode, pdp_op7_opcode, base_addr});
        end
      end
      npc = 12'($urandom);
      stall = 1'b0; PC_value = npc; step();
      checks++;
      if ({ifu_rd_req, ifu_rd_addr, ifd_valid, halted} !== {1'b1, npc, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rnd_next: got req=%b addr=%o valid=%b halted=%b want 1 %o 0 0", ifu_rd_req, ifu_rd_addr, ifd_valid, halted, npc);
      end
      pc = npc;
    end
  endtask

  task automatic test_reset_wait();
    int lat; logic [11:0] a, eb; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    mem[PC_value] = 12'o7402;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifu_rd_req, ifu_rd_addr, ifd_valid, base_addr, halted, pdp_mem_opcode, pdp_op7_opcode} !== 50'd0) begin
      errors++;
      $display("FAIL reset_wait_async: got %h want 0", {ifu_rd_req, ifu_rd_addr, ifd_valid, base_addr, halted});
    end
    PC_value = 12'o0300;
    step(); step();
    reset_n = 1'b1;
    fetch_to_valid(12'o0300, 12'o3123, 1'b0, lat, a);
    model(12'o3123, 12'o0300, em, eo, eb);
    checks++;
    if (lat !== 3 || a !== 12'o0300 ||
        {pdp_mem_opcode, pdp_op7_opcode, base_addr} !== {em, eo, eb}) begin
      errors++;
      $display("FAIL reset_wait_refetch: got lat=%0d addr=%o dec=%h want 3 0300 %h", lat, a,
               {pdp_mem_opcode, pdp_op7_opcode, base_addr}, {em, eo, eb});
    end
    stall = 1'b1; step();
    stall = 1'b0; PC_value = 12'o0400; step();
  endtask

  task automatic test_halt();
    int lat, rc; logic [11:0] a, eb; pdp_mem_opcode_s em; pdp_op7_opcode_s eo;
    fetch_to_valid(12'o0400, 12'o7402, 1'b0, lat, a);
    model(12'o7402, 12'o0400, em, eo, eb);
    checks++;
    if ({pdp_mem_opcode, pdp_op7_opcode} !== {em, eo} || pdp_op7_opcode.hlt !== 1'b1) begin
      errors++;
      $display("FAIL halt_decode: got %h want %h", {pdp_mem_opcode, pdp_op7_opcode}, {em, eo});
    end
    stall = 1'b1; step();
    stall = 1'b0; step();
    checks++;
    if ({halted, ifd_valid, ifu_rd_req} !== 3'b100) begin
      errors++;
      $display("FAIL halt_enter: got halted,valid,req=%b want 100", {halted, ifd_valid, ifu_rd_req});
    end
    rc = req_count;
    repeat (100) step();
    checks++;
    if (req_count !== rc || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_quiet: got %0d extra requests halted=%b want 0 1", req_count - rc, halted);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b want 0", halted); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'd0;
    test_reset();
    test_tad();
    test_jmp();
    test_group1();
    test_stall_hold();
    test_random();
    test_reset_wait();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
